// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU SRAM-like bus: arbiter FSM states, bus owner
// encoding and transfer size codes.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between instruction and data masters.
// Data wins contested rounds until the streak counter reaches its ceiling.
module arb_pick
  import cpu_bus_pkg::*;
#(
  parameter int STREAK_MAX = 2,
  parameter int SW         = 2
) (
  input  logic          inst_req,
  input  logic          data_req,
  input  logic [SW-1:0] streak,
  output logic          grant_valid,
  output owner_e        grant_owner
);

  logic starved;

  assign starved     = (streak == SW'(STREAK_MAX));
  assign grant_valid = inst_req | data_req;
  assign grant_owner = (data_req && !(inst_req && starved)) ? OWN_DATA : OWN_INST;

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave SRAM-like bus arbiter: one transaction in flight,
// data-priority with bounded instruction starvation.
module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 2
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction master
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data master
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // slave
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  mem_cmd_t      cmd_q, cmd_d;
  mem_cmd_t      inst_cmd, data_cmd;
  logic          arb_en;
  logic          grant_valid;
  owner_e        grant_owner;

  assign inst_cmd = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
  assign data_cmd = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

  arb_pick #(
    .STREAK_MAX (STREAK_MAX),
    .SW         (SW)
  ) u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .streak      (streak_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    cmd_d    = cmd_q;
    arb_en   = 1'b0;
    case (state_q)
      IDLE: arb_en = 1'b1;
      REQ:  if (mem_addr_ok) state_d = WAIT;
      WAIT: begin
        // completing cycle doubles as the next arbitration slot (no bubble)
        if (mem_data_ok) begin
          arb_en  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb_en && grant_valid) begin
      state_d = REQ;
      owner_d = grant_owner;
      if (grant_owner == OWN_DATA) begin
        cmd_d = data_cmd;
        if (inst_req && streak_q != STREAK_TOP) streak_d = streak_q + 1'b1;
      end else begin
        cmd_d    = inst_cmd;
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      owner_q  <= OWN_INST;
      streak_q <= '0;
      cmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      cmd_q    <= cmd_d;
    end
  end

  // handshakes are gated by registered state only, so no req->mem_req path
  assign mem_req   = (state_q == REQ);
  assign mem_wr    = cmd_q.wr;
  assign mem_size  = cmd_q.size;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  assign inst_addr_ok = (state_q == REQ)  && (owner_q == OWN_INST) && mem_addr_ok;
  assign data_addr_ok = (state_q == REQ)  && (owner_q == OWN_DATA) && mem_addr_ok;
  assign inst_data_ok = (state_q == WAIT) && (owner_q == OWN_INST) && mem_data_ok;
  assign data_data_ok = (state_q == WAIT) && (owner_q == OWN_DATA) && mem_data_ok;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule
